// File: rtl/func_eval_seq_pkg.sv
// Purpose: shared types and constants for the y = A*x + x^2*cos(K*(x-C)) sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, operator codes, IEEE-754 constants, default coefficients.
package func_eval_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MUL_AX,
    ST_MUL_XX,
    ST_SUB,
    ST_MUL_K,
    ST_COS,
    ST_MUL_P,
    ST_ADD,
    ST_OUT
  } state_t;

  localparam logic [1:0] FPU_MUL = 2'b00;
  localparam logic [1:0] FPU_ADD = 2'b01;
  localparam logic [1:0] FPU_SUB = 2'b10;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_EXP_MASK = 32'h7F80_0000;

  localparam logic [31:0] DEF_COEF_A = 32'h3F00_0000;  // 0.5
  localparam logic [31:0] DEF_COEF_C = 32'h4300_0000;  // 128.0
  localparam logic [31:0] DEF_COEF_K = 32'h3C00_0000;  // 1/128

  // Exponent all ones: NaN or infinity.
  function automatic logic is_nan_inf(input logic [31:0] f);
    return (f & FP_EXP_MASK) == FP_EXP_MASK;
  endfunction

endpackage

// File: rtl/func_eval_seq_if.sv
// Purpose: bundles the sample input, result output, error and both operator handshakes.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready and out_valid/out_ready; operators use start/done pulses.
// Modports: master = sequencer side, slave = source/sink/operator side.
interface func_eval_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [CW-1:0] in_ch;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [CW-1:0] out_ch;
  logic          err_timeout;
  logic          err_clr;
  logic          fpu_start;
  logic [1:0]    fpu_op;
  logic [31:0]   fpu_a;
  logic [31:0]   fpu_b;
  logic [31:0]   fpu_result;
  logic          fpu_done;
  logic          cos_start;
  logic [31:0]   cos_angle;
  logic [31:0]   cos_result;
  logic          cos_done;

  modport master (
    input  in_valid, in_data, in_ch, out_ready, err_clr,
           fpu_result, fpu_done, cos_result, cos_done,
    output in_ready, out_valid, out_data, out_ch, err_timeout,
           fpu_start, fpu_op, fpu_a, fpu_b, cos_start, cos_angle
  );

  modport slave (
    output in_valid, in_data, in_ch, out_ready, err_clr,
           fpu_result, fpu_done, cos_result, cos_done,
    input  in_ready, out_valid, out_data, out_ch, err_timeout,
           fpu_start, fpu_op, fpu_a, fpu_b, cos_start, cos_angle
  );
endinterface

// File: rtl/func_eval_seq_op_watchdog.sv
// Purpose: counts cycles spent waiting on an operator and flags a hang.
// Latency: o_timeout is combinational, asserted in the TIMEOUT-th cycle after start with no done.
// Backpressure: none; counter clears whenever not armed or on done.
// Ports: clk, rst_n, i_arm (waiting on an op), i_done (accepted done), o_timeout.
module op_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_arm,
  input  logic i_done,
  output logic o_timeout
);
  // The start cycle sees a count of 0 because the previous cycle was either
  // idle or the previous op's done, both of which clear the counter.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (!i_arm || i_done) r_cnt <= '0;
    else                       r_cnt <= r_cnt + 16'd1;
  end

  assign o_timeout = i_arm && !i_done && (r_cnt == LAST_CNT);
endmodule

// File: rtl/func_eval_seq.sv
// Purpose: steers one shared FP operator and one cosine unit to evaluate y = A*x + x^2*cos(K*(x-C)).
// Latency: sum over 7 ops of (operator latency + 1) + 1; NaN/Inf inputs bypass in 1 cycle.
// Backpressure: one sample in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk, rst_n, bus (func_eval_seq_if.master: sample in, result out, err, fpu_*, cos_*).
module func_eval_seq
  import func_eval_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter logic [31:0] COEF_A  = DEF_COEF_A,
  parameter logic [31:0] COEF_C  = DEF_COEF_C,
  parameter logic [31:0] COEF_K  = DEF_COEF_K,
  parameter int          TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  func_eval_seq_if.master bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t        r_state, w_state_nxt;
  logic          r_start;
  logic [31:0]   r_x, r_t1, r_t2, r_y;
  logic [31:0]   r_t34;  // x - C, then overwritten by the scaled angle
  logic [31:0]   r_t56;  // cosine, then overwritten by x^2 * cosine
  logic [CW-1:0] r_ch;
  logic          r_err;
  logic          w_is_op, w_nxt_is_op, w_cos_st;
  logic          w_fpu_ack, w_cos_ack, w_ack, w_accept, w_timeout;
  logic [1:0]    w_op;
  logic [31:0]   w_a, w_b, w_angle;

  assign w_is_op     = (r_state != ST_IDLE) && (r_state != ST_OUT);
  assign w_nxt_is_op = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_OUT);
  assign w_cos_st    = (r_state == ST_COS);
  // A done coinciding with start is illegal; the r_start mask also drops stale pulses.
  assign w_fpu_ack   = bus.fpu_done && !r_start && w_is_op && !w_cos_st;
  assign w_cos_ack   = bus.cos_done && !r_start && w_cos_st;
  assign w_ack       = w_fpu_ack || w_cos_ack;
  assign w_accept    = (r_state == ST_IDLE) && bus.in_valid;

  op_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_arm     (w_is_op),
    .i_done    (w_ack),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.in_valid) w_state_nxt = is_nan_inf(bus.in_data) ? ST_OUT : ST_MUL_AX;
      ST_MUL_AX: if (w_timeout) w_state_nxt = ST_IDLE; else if (w_ack) w_state_nxt = ST_MUL_XX;
      ST_MUL_XX: if (w_timeout) w_state_nxt = ST_IDLE; else if (w_ack) w_state_nxt = ST_SUB;
      ST_SUB:    if (w_timeout) w_state_nxt = ST_IDLE; else if (w_ack) w_state_nxt = ST_MUL_K;
      ST_MUL_K:  if (w_timeout) w_state_nxt = ST_IDLE; else if (w_ack) w_state_nxt = ST_COS;
      ST_COS:    if (w_timeout) w_state_nxt = ST_IDLE; else if (w_ack) w_state_nxt = ST_MUL_P;
      ST_MUL_P:  if (w_timeout) w_state_nxt = ST_IDLE; else if (w_ack) w_state_nxt = ST_ADD;
      ST_ADD:    if (w_timeout) w_state_nxt = ST_IDLE; else if (w_ack) w_state_nxt = ST_OUT;
      ST_OUT:    if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands depend only on state and temporaries that do not change while
  // waiting, so they stay stable from start until done.
  always_comb begin
    w_op    = FPU_MUL;
    w_a     = '0;
    w_b     = '0;
    w_angle = '0;
    unique case (r_state)
      ST_MUL_AX: begin w_a = COEF_A; w_b = r_x;    end
      ST_MUL_XX: begin w_a = r_x;    w_b = r_x;    end
      ST_SUB:    begin w_op = FPU_SUB; w_a = r_x; w_b = COEF_C; end
      ST_MUL_K:  begin w_a = r_t34;  w_b = COEF_K; end
      ST_COS:    w_angle = r_t34;
      ST_MUL_P:  begin w_a = r_t2;   w_b = r_t56;  end
      ST_ADD:    begin w_op = FPU_ADD; w_a = r_t1; w_b = r_t56; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 1'b0;
      r_x     <= '0;
      r_ch    <= '0;
      r_t1    <= '0;
      r_t2    <= '0;
      r_t34   <= '0;
      r_t56   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      // Consecutive op states always differ, so a state change marks entry.
      r_start <= w_nxt_is_op && (w_state_nxt != r_state);
      if (w_accept) begin
        r_x  <= bus.in_data;
        r_ch <= bus.in_ch;
        if (is_nan_inf(bus.in_data)) r_y <= bus.in_data;
      end
      if (w_ack) begin
        unique case (r_state)
          ST_MUL_AX: r_t1  <= bus.fpu_result;
          ST_MUL_XX: r_t2  <= bus.fpu_result;
          ST_SUB:    r_t34 <= bus.fpu_result;
          ST_MUL_K:  r_t34 <= bus.fpu_result;
          ST_COS:    r_t56 <= bus.cos_result;
          ST_MUL_P:  r_t56 <= bus.fpu_result;
          ST_ADD:    r_y   <= bus.fpu_result;
          default:   ;
        endcase
      end
      if (bus.err_clr)    r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE);
  assign bus.out_valid   = (r_state == ST_OUT);
  assign bus.out_data    = r_y;
  assign bus.out_ch      = r_ch;
  assign bus.err_timeout = r_err;
  assign bus.fpu_start   = r_start && !w_cos_st;
  assign bus.cos_start   = r_start && w_cos_st;
  assign bus.fpu_op      = w_op;
  assign bus.fpu_a       = w_a;
  assign bus.fpu_b       = w_b;
  assign bus.cos_angle   = w_angle;
endmodule

// File: tb/tb_func_eval_seq.sv
// Purpose: directed self-checking bench for func_eval_seq with 3-cycle fpu/cos models.
// Latency: n/a.
// Backpressure: exercises out_ready low, held in_valid, operator hang and mid-op reset.
module tb_func_eval_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  func_eval_seq_if #(.NUM_CH(4)) bus();

  func_eval_seq #(
    .NUM_CH (4),
    .COEF_A (32'h3F000000),
    .COEF_C (32'h43000000),
    .COEF_K (32'h3C000000),
    .TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real v;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real a;
    int  e;
    logic s;
    logic [23:0] m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 24'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(e), m[22:0]};
  endfunction

  logic [1:0] op_log[$];
  int fpu_cnt = 0;
  int cos_cnt = 0;
  bit cos_hang = 1'b0;

  initial begin : fpu_model
    int  pend;
    real ra, rb, rr;
    pend = 0;
    rr = 0.0;
    bus.fpu_done = 1'b0;
    bus.fpu_result = 32'h0;
    forever begin
      @(negedge clk);
      bus.fpu_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.fpu_done = 1'b1;
          bus.fpu_result = r2f(rr);
        end
      end
      if (bus.fpu_start) begin
        ra = f2r(bus.fpu_a);
        rb = f2r(bus.fpu_b);
        case (bus.fpu_op)
          2'b01:   rr = ra + rb;
          2'b10:   rr = ra - rb;
          default: rr = ra * rb;
        endcase
        op_log.push_back(bus.fpu_op);
        fpu_cnt++;
        pend = 3;
      end
    end
  end

  initial begin : cos_model
    int  pend;
    real rr;
    pend = 0;
    rr = 0.0;
    bus.cos_done = 1'b0;
    bus.cos_result = 32'h0;
    forever begin
      @(negedge clk);
      bus.cos_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.cos_done = 1'b1;
          bus.cos_result = r2f(rr);
        end
      end
      if (bus.cos_start) begin
        cos_cnt++;
        rr = $cos(f2r(bus.cos_angle));
        if (!cos_hang) pend = 3;
      end
    end
  end

  // Offers one sample while idle, returns cycles from acceptance to out_valid.
  task automatic run_sample(input logic [31:0] x, input logic [1:0] ch,
                            output int lat, output bit rdy_seen);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_ch    = ch;
    lat = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      if (bus.in_ready) rdy_seen = 1'b1;
    end while (!bus.out_valid && lat < 200);
  endtask

  task automatic post_hs(input string tag);
    @(negedge clk);
    chk({tag, "_vld_low"}, bus.out_valid, 1'b0);
    chk({tag, "_rdy_high"}, bus.in_ready, 1'b1);
  endtask

  initial begin : main
    int lat;
    int n;
    bit rdy_seen;
    bit stable;
    bit vld_seen;
    int f0, c0;
    logic [11:0] seq;

    bus.in_valid = 1'b0;
    bus.in_data = 32'h0;
    bus.in_ch = 2'd0;
    bus.out_ready = 1'b1;
    bus.err_clr = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_ch", bus.out_ch, 2'd0);
    chk("rst_err", bus.err_timeout, 1'b0);
    chk("rst_starts", {bus.fpu_start, bus.cos_start}, 2'b00);
    chk("rst_fpu_op", bus.fpu_op, 2'b00);
    chk("rst_operands", {bus.fpu_a, bus.fpu_b}, 64'h0);
    chk("rst_angle", bus.cos_angle, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // x = 128.0: 64 + 16384*cos(0) = 16448.0
    op_log.delete();
    c0 = cos_cnt;
    run_sample(32'h43000000, 2'd2, lat, rdy_seen);
    chk("t1_latency", lat, 29);
    chk("t1_data", bus.out_data, 32'h46808000);
    chk("t1_ch", bus.out_ch, 2'd2);
    chk("t1_nops", op_log.size(), 6);
    seq = 12'h0;
    foreach (op_log[i]) seq = {seq[9:0], op_log[i]};
    chk("t1_op_seq", seq, 12'b00_00_10_00_00_01);
    chk("t1_cos_pulses", cos_cnt - c0, 1);
    post_hs("t1");

    // x = 0.0: every product is zero
    run_sample(32'h00000000, 2'd0, lat, rdy_seen);
    chk("t2_latency", lat, 29);
    chk("t2_data", bus.out_data, 32'h0);
    chk("t2_ch", bus.out_ch, 2'd0);
    chk("t2_rdy_busy", rdy_seen, 1'b0);
    post_hs("t2");

    // NaN bypass
    f0 = fpu_cnt;
    c0 = cos_cnt;
    run_sample(32'h7FC00000, 2'd1, lat, rdy_seen);
    chk("t3_latency", lat, 1);
    chk("t3_data", bus.out_data, 32'h7FC00000);
    chk("t3_ch", bus.out_ch, 2'd1);
    post_hs("t3");
    chk("t3_no_fpu", fpu_cnt - f0, 0);
    chk("t3_no_cos", cos_cnt - c0, 0);

    // Output backpressure with a second sample waiting
    bus.out_ready = 1'b0;
    run_sample(32'h43000000, 2'd3, lat, rdy_seen);
    chk("t4_latency", lat, 29);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h00000000;
    bus.in_ch = 2'd1;
    stable = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h46808000 || bus.out_ch !== 2'd3)
        stable = 1'b0;
      if (bus.in_ready) rdy_seen = 1'b1;
    end
    chk("t4_hold_stable", stable, 1'b1);
    chk("t4_no_accept", rdy_seen, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_idle_after_hs", {bus.in_ready, bus.out_valid}, 2'b10);
    @(negedge clk);
    chk("t4_accepted", {bus.in_ready, bus.fpu_start}, 2'b01);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4b_latency", n, 28);
    chk("t4b_data", bus.out_data, 32'h0);
    chk("t4b_ch", bus.out_ch, 2'd1);
    post_hs("t4b");

    // Cosine unit hangs
    cos_hang = 1'b1;
    vld_seen = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h43000000;
    bus.in_ch = 2'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.cos_start && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) vld_seen = 1'b1;
    end
    chk("t5_cos_started", bus.cos_start, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.out_valid) vld_seen = 1'b1;
    end while (!bus.err_timeout && n < 50);
    chk("t5_timeout_cycles", n, 8);
    chk("t5_in_ready", bus.in_ready, 1'b1);
    chk("t5_no_result", vld_seen, 1'b0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("t5_err_cleared", bus.err_timeout, 1'b0);
    cos_hang = 1'b0;
    @(negedge clk);

    // Reset during MUL_XX; the pending fpu_done lands after release
    bus.in_valid = 1'b1;
    bus.in_data = 32'h43000000;
    bus.in_ch = 2'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!(bus.fpu_start && bus.fpu_a == 32'h43000000) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_mulxx_started", bus.fpu_b, 32'h43000000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ready", {bus.in_ready, bus.out_valid, bus.fpu_start}, 3'b100);
    chk("t6_rst_operands", {bus.fpu_a, bus.fpu_b}, 64'h0);
    chk("t6_rst_ch", bus.out_ch, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_stale_ignored", {bus.in_ready, bus.out_valid, bus.fpu_start, bus.cos_start}, 4'b1000);
    run_sample(32'h43000000, 2'd2, lat, rdy_seen);
    chk("t6_latency", lat, 29);
    chk("t6_data", bus.out_data, 32'h46808000);
    chk("t6_ch", bus.out_ch, 2'd2);
    post_hs("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/func_eval_seq.md
Name: func_eval_seq

Overview:
- Sequencer that evaluates y = A*x + x^2*cos(K*(x - C)) on IEEE-754 single-precision samples from NUM_CH logical channels.
- Shares one external FP operator (mul/add/sub) and one external cosine unit (float in, float out; conversion is internal to that unit) through start/done handshakes, instead of one operator per term.
- Accepts samples on a valid/ready input, returns tagged results on a valid/ready output, and flags operator hangs.
- Sits between the sample source and the result sink; the operator instances sit beside it.

Parameters:
- NUM_CH, 4, number of channel tags; tag width CW = max(1, clog2(NUM_CH)).
- COEF_A, 32'h3F000000, linear coefficient A (0.5).
- COEF_C, 32'h43000000, angle offset C (128.0).
- COEF_K, 32'h3C000000, angle scale K (1/128).
- TIMEOUT, 255, maximum cycles to wait for any operator done; range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  block idle and able to accept
- in_data  in  32  sample x (float)
- in_ch  in  CW  channel tag of x
- out_valid  out  1  result held
- out_ready  in  1  sink accepts result
- out_data  out  32  result y (float)
- out_ch  out  CW  tag of y, equal to the accepted in_ch
- err_timeout  out  1  sticky; set on operator timeout
- err_clr  in  1  clears err_timeout
- fpu_start  out  1  one-cycle pulse requesting an operation
- fpu_op  out  2  00 mul, 01 add, 10 sub; held stable until done
- fpu_a, fpu_b  out  32  operands; held stable until done
- fpu_result  in  32  valid in the cycle fpu_done=1
- fpu_done  in  1  one-cycle completion pulse
- cos_start  out  1  one-cycle pulse
- cos_angle  out  32  float angle (radians); held until done
- cos_result  in  32  float cosine; valid with cos_done
- cos_done  in  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; out_data=0; out_ch=0; err_timeout=0; fpu_start=0; cos_start=0; fpu_op=00; fpu_a=fpu_b=cos_angle=0; all temporaries 0.
- Reset mid-operation aborts the sample. Late done pulses arriving after reset release and before the next start are ignored.
- IDLE: in_ready=1. On in_valid, latch x and tag, go to the first op state. in_ready=0 in every other state.
- NaN/Inf input (exponent 8'hFF): skip all ops, y=x, go directly to OUT. Result appears one cycle after acceptance.
- Op states in order, each capturing its result on done:
  - MUL_AX: t1 = A*x
  - MUL_XX: t2 = x*x
  - SUB: t3 = x - C
  - MUL_K: t4 = t3*K
  - COS: t5 = cos(t4)
  - MUL_P: t6 = t2*t5
  - ADD: y = t1 + t6
- Op-state handshake:
  - On entry, assert start for exactly one cycle; operands and op code are valid in that cycle and stay stable until done.
  - done in the same cycle as start is illegal and ignored.
  - Capture on the first done; the next op's start follows in the cycle after done.
  - Latency (acceptance to out_valid) = sum over the seven ops of (operator latency + 1) + 1.
- Watchdog: a per-state counter restarts at start. If it reaches TIMEOUT with no done:
  - set err_timeout;
  - drop the sample (no out_valid);
  - return to IDLE.
  - err_clr wins over a simultaneous set.
- OUT: out_valid=1, with out_data and out_ch stable until the cycle where out_valid and out_ready are both 1; then go to IDLE.
- A new sample is accepted no earlier than the cycle after the handshake (no pass-through).
- done pulses outside the matching wait state are ignored.
- No arithmetic is performed in this block; it only steers operands and captures results.

Decomposition:
- Shared package func_eval_pkg holds:
  - state enum;
  - fpu_op encodings;
  - FP_QNAN and exponent-all-ones mask constants;
  - default coefficient constants.
- One sub-module, op_watchdog: counter with start/done/timeout, instantiated once and shared by both operator handshakes.

Test Plan:
- Bench setup: the bench drives fpu/cos behavioural models with a fixed latency of 3 cycles.
- x=32'h43000000 (128.0), tag 2, out_ready=1 -> out_data=32'h46808000 (16448.0), out_ch=2. out_valid rises exactly 29 cycles after acceptance; fpu_op sequence is 00,00,10,00,00,01 and cos_start pulses once.
- x=32'h00000000, tag 0 -> out_data=32'h00000000 after the full op sequence; in_ready=0 throughout until after out handshake.
- x=32'h7FC00000 (NaN) -> no fpu_start/cos_start pulses; out_data=32'h7FC00000 one cycle after acceptance.
- out_ready held low 10 cycles after result -> out_valid, out_data, out_ch stable for those cycles; in_valid held high stays unaccepted until the cycle after the handshake.
- cos model never responds, TIMEOUT=8 -> err_timeout=1 at 8 cycles after cos_start, no out_valid, in_ready=1 next cycle; err_clr pulse -> err_timeout=0.
- rst_n low during MUL_XX, then a stale fpu_done after release -> outputs at reset values, done ignored; next sample x=128.0 gives 32'h46808000.
